// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl - fetch PC sequencer with redirect buffering.
//
// Holds the registered fetch PC and picks the next PC from PC+4 or one of
// three redirect sources: jr > j > br. When the hazard unit stalls, a
// redirect that arrives in the same cycle is captured in a one-entry buffer.
// That buffered redirect is applied on the first cycle without a stall.
//
// Optional feature macro: PC_EXC_EN adds an exception entry path (exc_req /
// exc_sel). The exception beats everything, including stall and a buffered
// redirect.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   stall      - hold request; the PC does not advance while high
//   br_req     - taken branch, target br_target
//   j_req      - J/JAL redirect, target j_target
//   jr_req     - JR/JALR redirect, target jr_target
//   exc_req    - exception entry request (PC_EXC_EN only)
//   exc_sel    - exception path selected, combinational (PC_EXC_EN only)
//   pc         - registered fetch PC
//   npc        - combinational next PC
//   pc_op      - next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//   redirect   - one-cycle pulse after a non-sequential PC load
//   pend       - a redirect is buffered (HOLD state)
//   misalign   - sticky: a PC with bits [1:0] != 0 was loaded
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        j_req,
  input  logic [31:0] j_target,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
`ifdef PC_EXC_EN
  input  logic        exc_req,
  output logic        exc_sel,
`endif
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [1:0]  pc_op,
  output logic        redirect,
  output logic        pend,
  output logic        misalign
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [1:0] OP_SEQ = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  localparam logic [1:0] OP_JR  = 2'b11;

  logic [0:0]  state_q, state_d;
  logic [1:0]  bufOp_q, bufOp_d;
  logic [31:0] bufTgt_q, bufTgt_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pcSeq;
  logic [1:0]  reqOp;
  logic [31:0] reqTgt;
  logic        loadEn;

  // The 32-bit add wraps naturally, so FFFF_FFFC + 4 gives 0000_0000.
  assign pcSeq = pc_q + 32'd4;

  // Resolve the request sources by fixed priority. Requests that lose in
  // the same cycle are dropped. They are never queued.
  always_comb begin
    reqOp  = OP_SEQ;
    reqTgt = pcSeq;
    if (jr_req) begin
      reqOp  = OP_JR;
      reqTgt = jr_target;
    end else if (j_req) begin
      reqOp  = OP_J;
      reqTgt = j_target;
    end else if (br_req) begin
      reqOp  = OP_BR;
      reqTgt = br_target;
    end
  end

  // Next-state logic.
  // In RUN, the PC follows the winning request when there is no stall.
  // If there is a stall, the winning request is captured in the buffer.
  // In HOLD, the buffered redirect is applied once the stall drops. Any new
  // requests are ignored until that happens. npc/pc_op show what the PC
  // will become if the stall drops.
  always_comb begin
    state_d    = state_q;
    bufOp_d    = bufOp_q;
    bufTgt_d   = bufTgt_q;
    npc        = pc_q;
    pc_op      = OP_SEQ;
    loadEn     = 1'b0;
    redirect_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          npc        = reqTgt;
          pc_op      = reqOp;
          loadEn     = 1'b1;
          redirect_d = (reqOp != OP_SEQ);
        end else if (reqOp != OP_SEQ) begin
          bufOp_d  = reqOp;
          bufTgt_d = reqTgt;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        npc   = bufTgt_q;
        pc_op = bufOp_q;
        if (!stall) begin
          loadEn     = 1'b1;
          redirect_d = 1'b1;
          bufOp_d    = OP_SEQ;
          bufTgt_d   = '0;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
`ifdef PC_EXC_EN
    // The exception entry beats stall and discards any buffered redirect.
    // pc_op reads 00 because the exception path is outside the 2-bit mux.
    if (exc_req) begin
      npc        = EXC_PC;
      pc_op      = OP_SEQ;
      loadEn     = 1'b1;
      redirect_d = 1'b1;
      bufOp_d    = OP_SEQ;
      bufTgt_d   = '0;
      state_d    = ST_RUN;
    end
`endif
    pc_d       = loadEn ? npc : pc_q;
    misalign_d = misalign_q | (loadEn & (npc[1:0] != 2'b00));
  end

  // State registers. The synchronous reset beats stall, all requests and a
  // buffered redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_RUN;
      bufOp_q    <= OP_SEQ;
      bufTgt_q   <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      bufOp_q    <= bufOp_d;
      bufTgt_q   <= bufTgt_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_EXC_EN
  assign exc_sel = exc_req;
`else
  // EXC_PC has no function without the exception path.
  logic unusedExcPc;
  assign unusedExcPc = ^EXC_PC;
`endif

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign pend     = (state_q == ST_HOLD);
  assign misalign = misalign_q;

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180, exception entry address (used only with PC_EXC_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  hazard-unit hold request; PC SHALL NOT advance while high.
REQ-006 br_req  input  1  conditional branch resolved taken in ID.
REQ-007 br_target  input  32  branch target address.
REQ-008 j_req  input  1  J/JAL redirect request.
REQ-009 j_target  input  32  jump target address.
REQ-010 jr_req  input  1  JR/JALR redirect request.
REQ-011 jr_target  input  32  register jump target.
REQ-012 pc  output  32  registered current fetch PC.
REQ-013 npc  output  32  combinational next PC.
REQ-014 pc_op  output  2  next-PC mux select: 00 PC+4, 01 branch, 10 jump, 11 jr.
REQ-015 redirect  output  1  registered one-cycle pulse, high the cycle after a non-sequential PC is loaded.
REQ-016 pend  output  1  high while a redirect is buffered (state HOLD).
REQ-017 misalign  output  1  sticky flag; PC loaded with bits [1:0] != 0.

Function
REQ-018 FSM states RUN (no buffered redirect) and HOLD (redirect buffered); 2-bit op + 32-bit target buffer.
REQ-019 Request priority jr_req > j_req > br_req > sequential; lower requests in same cycle are dropped.
REQ-020 RUN, stall=0: pc <= npc next edge; npc = selected target or pc+4; pc_op = selected code.
REQ-021 RUN, stall=1, any req: buffer winning op/target, pc held, -> HOLD.
REQ-022 RUN, stall=1, no req: pc held, npc = pc, pc_op = 00.
REQ-023 HOLD, stall=1: pc held; npc = buffered target; pc_op = buffered op; new reqs ignored.
REQ-024 HOLD, stall=0: pc <= buffered target, buffer cleared, -> RUN; reqs in this cycle ignored.
REQ-025 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 redirect SHALL pulse exactly once per applied non-sequential load; never for PC+4 loads.
REQ-027 Targets loaded unmodified; misalign set on load with [1:0] != 0, cleared only by reset.

Reset
REQ-028 rst_n=0 at edge: pc=RESET_PC, state RUN, buffer cleared, pend=0, redirect=0, misalign=0.
REQ-029 Reset overrides stall and all requests, including mid-HOLD (buffered redirect discarded).
REQ-030 First edge after release with stall=0 and no req: pc = RESET_PC+4.

Configuration
REQ-031 Macro PC_EXC_EN defined: adds exc_req input 1 and exc_sel output 1; exc_req has top priority, overrides stall and HOLD, pc <= EXC_PC next edge, buffer cleared, -> RUN, redirect pulses; exc_sel = exc_req combinationally, pc_op = 00 while exc_sel=1.
REQ-032 Macro undefined: exc_req/exc_sel ports absent, EXC_PC unused, behaviour per REQ-018..030 only.

Verification
REQ-033 Reset release, 3 idle cycles -> pc 3000, 3004, 3008, 300C; pc_op=00; redirect=0.
REQ-034 pc=3010, br_req+j_req+jr_req same cycle, targets 3100/3200/3300 -> pc_op=11, pc=3300 next, redirect pulse 1 cycle.
REQ-035 pc=3020, stall=1 with br_req target 3400, stall held 3 cycles, j_req 3500 in cycle 2 -> pend=1, pc stays 3020, then pc=3400 after stall drop, 3500 never loaded.
REQ-036 pc=FFFF_FFFC (via jr), idle -> pc=0000_0000; jr_target 3002 -> misalign=1, stays 1 until rst_n=0.
REQ-037 rst_n=0 during HOLD with buffered 3600 -> pc=3000, pend=0, 3600 never loaded.
REQ-038 PC_EXC_EN: stall=1 HOLD buffered 3700, exc_req=1 -> pc=4180 next edge, pend=0, exc_sel=1 that cycle.
